// File: rtl/spihost.sv
// spihost: SPI master for one spinet port.
// One WIDTH-bit MSB-first word per SS-low frame, started from node flags.
module spihost #(
  parameter int WIDTH = 16,
  parameter int DIV   = 4,
  parameter int GAP   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  input  logic             node_txready,
  input  logic             node_rxready,
  output logic             SCLK,
  output logic             SS,
  output logic             MOSI,
  input  logic             MISO
);

  localparam int CMAX = (GAP > DIV) ? GAP : DIV;
  localparam int CW   = $clog2(CMAX);
  localparam int BW   = $clog2(WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_GAP
  } state_t;

  state_t state, state_n;

  logic [CW-1:0]    cnt;
  logic [BW-1:0]    bit_cnt;
  logic             tx_full;
  logic [WIDTH-1:0] tx_hold;
  logic [WIDTH-2:0] tx_sh;
  logic [WIDTH-1:0] rx_sh;

  logic div_end, gap_end, last_low;
  logic use_tx, start;
  logic ld, rise, fall, done;

  assign div_end  = (cnt == CW'(DIV - 1));
  assign gap_end  = (cnt == CW'(GAP - 1));
  // bit_cnt has wrapped back to 0 only after the final falling edge
  assign last_low = ~SCLK & div_end & (bit_cnt == '0);
  assign use_tx   = tx_full & node_txready;
  assign start    = ~rx_valid & (use_tx | node_rxready);
  assign tx_ready = ~tx_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (start)    state_n = S_SETUP;
      S_SETUP: if (div_end)  state_n = S_SHIFT;
      S_SHIFT: if (last_low) state_n = S_HOLD;
      S_HOLD:  if (div_end)  state_n = S_GAP;
      S_GAP:   if (gap_end)  state_n = S_IDLE;
      default:               state_n = S_IDLE;
    endcase
  end

  always_comb begin
    ld   = 1'b0;
    rise = 1'b0;
    fall = 1'b0;
    done = 1'b0;
    unique case (1'b1)
      state == S_IDLE:  ld = start;
      state == S_SETUP: rise = div_end;
      state == S_SHIFT: begin
        fall = SCLK & div_end;
        rise = ~SCLK & div_end & (bit_cnt != '0);
      end
      state == S_HOLD:  done = div_end;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      bit_cnt  <= '0;
      tx_full  <= 1'b0;
      tx_hold  <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      SCLK     <= 1'b0;
      SS       <= 1'b1;
      MOSI     <= 1'b0;
    end else begin
      if (state != state_n || state == S_IDLE || rise || fall)
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;

      if (tx_valid & ~tx_full) begin
        tx_hold <= tx_data;
        tx_full <= 1'b1;
      end else if (ld & use_tx) begin
        tx_full <= 1'b0;
      end

      if (done & rx_sh[WIDTH-1]) begin
        rx_data  <= rx_sh;
        rx_valid <= 1'b1;
      end else if (rx_valid & rx_ready) begin
        rx_valid <= 1'b0;
      end

      if (ld) begin
        SS      <= 1'b0;
        MOSI    <= use_tx & tx_hold[WIDTH-1];
        tx_sh   <= use_tx ? tx_hold[WIDTH-2:0] : '0;
        rx_sh   <= '0;
        bit_cnt <= '0;
      end

      if (rise) begin
        SCLK <= 1'b1;
        // bit 0 was already presented in SETUP
        if (state == S_SHIFT) begin
          MOSI  <= tx_sh[WIDTH-2];
          tx_sh <= {tx_sh[WIDTH-3:0], 1'b0};
        end
      end

      if (fall) begin
        SCLK    <= 1'b0;
        rx_sh   <= {rx_sh[WIDTH-2:0], MISO};
        bit_cnt <= bit_cnt + 1'b1;
      end

      if (done) begin
        SS   <= 1'b1;
        MOSI <= 1'b0;
      end
    end
  end

endmodule
